// File: rtl/edge_detector_stream_if.sv
// rtl/edge_detector_stream_if.sv - pixel column in / squared-delta edge result out bundle
interface edge_detector_stream_if #(
    parameter int CHANNELS = 8,
    parameter int PIXEL_W  = 8,
    parameter int SQ_W     = 2 * PIXEL_W
);
    logic                         in_valid;
    logic [CHANNELS*PIXEL_W-1:0]  in_pixels;
    logic                         out_valid;
    logic [CHANNELS*SQ_W-1:0]     dist_sq;
    logic [CHANNELS-1:0]          edge_flags;
    logic                         primed;

    // master is the pixel source / result consumer side, slave is the detector
    modport master (
        output in_valid,
        output in_pixels,
        input  out_valid,
        input  dist_sq,
        input  edge_flags,
        input  primed
    );

    modport slave (
        input  in_valid,
        input  in_pixels,
        output out_valid,
        output dist_sq,
        output edge_flags,
        output primed
    );
endinterface

// File: rtl/edge_detector_stream.sv
// rtl/edge_detector_stream.sv - per-channel boxcar average, lagged delta, squared, thresholded
module edge_detector_stream #(
    parameter int CHANNELS = 8,
    parameter int PIXEL_W  = 8,
    parameter int AVG_LOG2 = 2,
    parameter int LAG      = 4,
    parameter int SQ_W     = 2 * PIXEL_W
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic                 flush,
    input  logic [SQ_W-1:0]      threshold,
    edge_detector_stream_if.slave bus
);

    localparam int WIN     = 1 << AVG_LOG2;
    localparam int SUM_W   = PIXEL_W + AVG_LOG2;
    localparam int PRIME_N = WIN + LAG;
    localparam int CNT_W   = $clog2(PRIME_N + 1);

    // S1 state: averaging window, running sums, prime counter
    logic [PIXEL_W-1:0]        win_q    [CHANNELS][WIN];
    logic [SUM_W-1:0]          sum_q    [CHANNELS];
    logic [PIXEL_W-1:0]        avg_q    [CHANNELS];
    logic [CNT_W-1:0]          cnt_q;
    logic                      s1_valid;
    logic                      s1_primed;

    // S2 state: lag line of averages and the signed delta
    logic [PIXEL_W-1:0]        lag_q    [CHANNELS][LAG];
    logic signed [PIXEL_W:0]   delta_q  [CHANNELS];
    logic                      s2_valid;
    logic                      s2_primed;

    // S3 state: squared distance
    logic [SQ_W-1:0]           dist_q   [CHANNELS];
    logic                      s3_valid;
    logic                      s3_primed;

    // S4 state: registered outputs
    logic                      out_valid_q;
    logic [CHANNELS*SQ_W-1:0]  out_dist_q;
    logic [CHANNELS-1:0]       out_flags_q;
    logic                      out_primed_q;

    logic [PIXEL_W-1:0]        pix       [CHANNELS];
    logic [SUM_W-1:0]          sum_next  [CHANNELS];
    logic signed [PIXEL_W:0]   delta_next[CHANNELS];
    logic [PIXEL_W:0]          delta_neg [CHANNELS];
    logic [PIXEL_W-1:0]        mag       [CHANNELS];
    logic [CHANNELS-1:0]       flags_next;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            pix[c]      = bus.in_pixels[c*PIXEL_W +: PIXEL_W];
            sum_next[c] = sum_q[c] + SUM_W'(pix[c]) - SUM_W'(win_q[c][WIN-1]);
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int c = 0; c < CHANNELS; c++) begin
                sum_q[c] <= '0;
                avg_q[c] <= '0;
                for (int i = 0; i < WIN; i++) win_q[c][i] <= '0;
            end
            cnt_q     <= '0;
            s1_valid  <= 1'b0;
            s1_primed <= 1'b0;
        end else if (flush) begin
            for (int c = 0; c < CHANNELS; c++) begin
                sum_q[c] <= '0;
                avg_q[c] <= '0;
                for (int i = 0; i < WIN; i++) win_q[c][i] <= '0;
            end
            cnt_q     <= '0;
            s1_valid  <= 1'b0;
            s1_primed <= 1'b0;
        end else begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    sum_q[c]    <= sum_next[c];
                    avg_q[c]    <= sum_next[c][SUM_W-1:AVG_LOG2];
                    win_q[c][0] <= pix[c];
                    for (int i = 1; i < WIN; i++) win_q[c][i] <= win_q[c][i-1];
                end
                if (cnt_q != CNT_W'(PRIME_N)) cnt_q <= cnt_q + CNT_W'(1);
                // this sample is the PRIME_N-th accepted one or later
                s1_primed <= (cnt_q >= CNT_W'(PRIME_N - 1));
            end
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            delta_next[c] = $signed({1'b0, avg_q[c]}) - $signed({1'b0, lag_q[c][LAG-1]});
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int c = 0; c < CHANNELS; c++) begin
                delta_q[c] <= '0;
                for (int i = 0; i < LAG; i++) lag_q[c][i] <= '0;
            end
            s2_valid  <= 1'b0;
            s2_primed <= 1'b0;
        end else if (flush) begin
            for (int c = 0; c < CHANNELS; c++) begin
                delta_q[c] <= '0;
                for (int i = 0; i < LAG; i++) lag_q[c][i] <= '0;
            end
            s2_valid  <= 1'b0;
            s2_primed <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    delta_q[c]  <= delta_next[c];
                    lag_q[c][0] <= avg_q[c];
                    for (int i = 1; i < LAG; i++) lag_q[c][i] <= lag_q[c][i-1];
                end
                s2_primed <= s1_primed;
            end
        end
    end

    // |delta| never exceeds 2**PIXEL_W-1, so squaring the magnitude fits SQ_W exactly
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            delta_neg[c] = -delta_q[c];
            mag[c]       = delta_q[c][PIXEL_W] ? delta_neg[c][PIXEL_W-1:0]
                                               : delta_q[c][PIXEL_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int c = 0; c < CHANNELS; c++) dist_q[c] <= '0;
            s3_valid  <= 1'b0;
            s3_primed <= 1'b0;
        end else if (flush) begin
            for (int c = 0; c < CHANNELS; c++) dist_q[c] <= '0;
            s3_valid  <= 1'b0;
            s3_primed <= 1'b0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    dist_q[c] <= SQ_W'(mag[c]) * SQ_W'(mag[c]);
                end
                s3_primed <= s2_primed;
            end
        end
    end

    always_comb begin
        flags_next = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            flags_next[c] = s3_primed && (dist_q[c] > threshold);
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            out_valid_q  <= 1'b0;
            out_dist_q   <= '0;
            out_flags_q  <= '0;
            out_primed_q <= 1'b0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            out_dist_q   <= '0;
            out_flags_q  <= '0;
            out_primed_q <= 1'b0;
        end else begin
            out_valid_q <= s3_valid;
            if (s3_valid) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    out_dist_q[c*SQ_W +: SQ_W] <= dist_q[c];
                end
                out_flags_q  <= flags_next;
                out_primed_q <= s3_primed;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.dist_sq    = out_dist_q;
    assign bus.edge_flags = out_flags_q;
    assign bus.primed     = out_primed_q;

endmodule

// File: tb/tb_edge_detector_stream.sv
// tb/tb_edge_detector_stream.sv - randomized bench with a sample-history reference model
module tb_edge_detector_stream;
    localparam int CH  = 2;
    localparam int PW  = 8;
    localparam int AL  = 2;
    localparam int LG  = 4;
    localparam int SW  = 16;
    localparam int WIN = 1 << AL;

    logic          clock  = 1'b0;
    logic          resetN = 1'b0;
    logic          flush  = 1'b0;
    logic [SW-1:0] threshold = 16'd9999;

    edge_detector_stream_if #(.CHANNELS(CH), .PIXEL_W(PW), .SQ_W(SW)) bus();

    edge_detector_stream #(
        .CHANNELS(CH), .PIXEL_W(PW), .AVG_LOG2(AL), .LAG(LG), .SQ_W(SW)
    ) dut (
        .clock(clock),
        .resetN(resetN),
        .flush(flush),
        .threshold(threshold),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] d1;
        logic [15:0] d0;
        logic        pr;
    } exp_t;

    exp_t        expq[$];
    int          hist0[$];
    int          hist1[$];
    logic [31:0] last_d;
    logic [1:0]  last_f;
    logic        last_p;

    // average of the WIN samples ending at accepted sample n; history before sample 0 is zero
    function automatic int avg_of(input int ch, input int n);
        int s;
        s = 0;
        if (n < 0) return 0;
        for (int k = n - WIN + 1; k <= n; k++) begin
            if (k >= 0) s += (ch == 0) ? hist0[k] : hist1[k];
        end
        return s / WIN;
    endfunction

    always @(posedge clock) begin : monitor
        bit          cap_v, cap_f, cap_r;
        logic [15:0] cap_thr;
        int          n, d0, d1;
        exp_t        e;
        logic [1:0]  ef;
        cap_r   = resetN;
        cap_f   = flush;
        cap_v   = bus.in_valid;
        cap_thr = threshold;
        if (!cap_r || cap_f) begin
            expq.delete();
            hist0.delete();
            hist1.delete();
            last_d = '0;
            last_f = '0;
            last_p = 1'b0;
        end else if (cap_v) begin
            n = hist0.size();
            hist0.push_back(int'(bus.in_pixels[7:0]));
            hist1.push_back(int'(bus.in_pixels[15:8]));
            d0 = avg_of(0, n) - avg_of(0, n - LG);
            d1 = avg_of(1, n) - avg_of(1, n - LG);
            e.d0 = 16'(d0 * d0);
            e.d1 = 16'(d1 * d1);
            e.pr = (n >= WIN + LG - 1);
            expq.push_back(e);
        end
        #1;
        if (bus.out_valid) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL mon_unexpected_valid got out_valid=1 required no pending result");
            end else begin
                e = expq.pop_front();
                ef[0] = e.pr && (e.d0 > cap_thr);
                ef[1] = e.pr && (e.d1 > cap_thr);
                total++;
                if (bus.dist_sq !== {e.d1, e.d0}) begin
                    bad++;
                    $display("FAIL mon_dist got=%h required=%h", bus.dist_sq, {e.d1, e.d0});
                end
                total++;
                if (bus.edge_flags !== ef) begin
                    bad++;
                    $display("FAIL mon_flags got=%b required=%b", bus.edge_flags, ef);
                end
                total++;
                if (bus.primed !== e.pr) begin
                    bad++;
                    $display("FAIL mon_primed got=%b required=%b", bus.primed, e.pr);
                end
                last_d = {e.d1, e.d0};
                last_f = ef;
                last_p = e.pr;
            end
        end else begin
            total++;
            if (bus.dist_sq !== last_d || bus.edge_flags !== last_f || bus.primed !== last_p) begin
                bad++;
                $display("FAIL mon_hold got=%h/%b/%b required=%h/%b/%b", bus.dist_sq,
                         bus.edge_flags, bus.primed, last_d, last_f, last_p);
            end
        end
    end

    task automatic tick(input bit v, input int p0, input int p1, input bit f);
        bus.in_valid  = v;
        bus.in_pixels = {8'(p1), 8'(p0)};
        flush         = f;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b required=0", bus.out_valid); end
        total++;
        if (bus.dist_sq !== '0) begin bad++; $display("FAIL reset_dist got=%h required=0", bus.dist_sq); end
        total++;
        if (bus.edge_flags !== '0) begin bad++; $display("FAIL reset_flags got=%b required=0", bus.edge_flags); end
        total++;
        if (bus.primed !== 1'b0) begin bad++; $display("FAIL reset_primed got=%b required=0", bus.primed); end
        resetN = 1'b1;
    endtask

    task automatic test_constant();
        int nv;
        nv = 0;
        threshold = 16'd9999;
        for (int i = 0; i < 26; i++) begin
            if (i < 20) tick(1'b1, 100, 100, 1'b0);
            else        tick(1'b0, 0, 0, 1'b0);
            if (bus.out_valid) begin
                total++;
                if (bus.primed !== (nv >= 7)) begin
                    bad++;
                    $display("FAIL const_primed idx=%0d got=%b required=%b", nv, bus.primed, nv >= 7);
                end
                total++;
                if (bus.edge_flags !== 2'b00) begin
                    bad++;
                    $display("FAIL const_flags idx=%0d got=%b required=00", nv, bus.edge_flags);
                end
                if (nv >= 7) begin
                    total++;
                    if (bus.dist_sq !== '0) begin
                        bad++;
                        $display("FAIL const_dist idx=%0d got=%h required=0", nv, bus.dist_sq);
                    end
                end
                nv++;
            end
        end
        total++;
        if (nv != 20) begin bad++; $display("FAIL const_count got=%0d required=20", nv); end
    endtask

    task automatic test_latency();
        for (int k = 1; k <= 6; k++) begin
            tick(k == 1, 7, 9, 1'b0);
            total++;
            if (bus.out_valid !== (k == 4)) begin
                bad++;
                $display("FAIL latency edge=t+%0d got=%b required=%b", k, bus.out_valid, k == 4);
            end
        end
    endtask

    task automatic test_step(input bit bubbles);
        int step_d[8] = '{2500, 10000, 22500, 40000, 22500, 10000, 2500, 0};
        bit step_f[8] = '{0, 1, 1, 1, 1, 1, 0, 0};
        bit sv[$];
        int sp[$];
        int idx;
        logic [1:0] want;
        threshold = 16'd9999;
        tick(1'b0, 0, 0, 1'b1);
        for (int k = 0; k < 22; k++) begin
            sv.push_back(1'b1);
            sp.push_back(k < 10 ? 0 : 200);
            if (bubbles) begin
                sv.push_back(1'b0);
                sp.push_back(0);
            end
        end
        for (int k = 0; k < 8; k++) begin
            sv.push_back(1'b0);
            sp.push_back(0);
        end
        idx = 0;
        for (int i = 0; i < sv.size(); i++) begin
            tick(sv[i], sp[i], 0, 1'b0);
            if (bus.out_valid) begin
                if (idx >= 10 && idx < 18) begin
                    want = {1'b0, step_f[idx-10]};
                    total++;
                    if (bus.dist_sq[15:0] !== 16'(step_d[idx-10])) begin
                        bad++;
                        $display("FAIL step_dist b=%0d i=%0d got=%0d required=%0d", bubbles,
                                 idx - 10, bus.dist_sq[15:0], step_d[idx-10]);
                    end
                    total++;
                    if (bus.edge_flags !== want) begin
                        bad++;
                        $display("FAIL step_flags b=%0d i=%0d got=%b required=%b", bubbles,
                                 idx - 10, bus.edge_flags, want);
                    end
                end
                idx++;
            end
        end
        total++;
        if (idx != 22) begin bad++; $display("FAIL step_count b=%0d got=%0d required=22", bubbles, idx); end
    endtask

    task automatic test_flush();
        int nv;
        threshold = 16'd9999;
        tick(1'b0, 0, 0, 1'b1);
        for (int k = 0; k < 10; k++) tick(1'b1, 0, 0, 1'b0);
        tick(1'b1, 200, 0, 1'b0);
        tick(1'b1, 200, 0, 1'b0);
        tick(1'b1, 200, 0, 1'b1);
        total++;
        if (bus.out_valid !== 1'b0 || bus.dist_sq !== '0) begin
            bad++;
            $display("FAIL flush_clear got=%b/%h required=0/0", bus.out_valid, bus.dist_sq);
        end
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 0, 0, 1'b0);
            total++;
            if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop k=%0d got=1 required=0", k); end
        end
        nv = 0;
        for (int k = 0; k < 16; k++) begin
            tick(k < 10, 200, 0, 1'b0);
            if (bus.out_valid) begin
                total++;
                if (bus.primed !== (nv >= 7)) begin
                    bad++;
                    $display("FAIL flush_primed idx=%0d got=%b required=%b", nv, bus.primed, nv >= 7);
                end
                nv++;
            end
        end
        total++;
        if (nv != 10) begin bad++; $display("FAIL flush_count got=%0d required=10", nv); end
    endtask

    task automatic test_reset_mid();
        int nv;
        threshold = 16'd50;
        for (int k = 0; k < 14; k++) tick(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 1'b0);
        #2;
        resetN = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b required=0", bus.out_valid); end
        total++;
        if (bus.dist_sq !== '0) begin bad++; $display("FAIL rmid_dist got=%h required=0", bus.dist_sq); end
        total++;
        if (bus.edge_flags !== '0) begin bad++; $display("FAIL rmid_flags got=%b required=0", bus.edge_flags); end
        total++;
        if (bus.primed !== 1'b0) begin bad++; $display("FAIL rmid_primed got=%b required=0", bus.primed); end
        bus.in_valid = 1'b0;
        @(posedge clock);
        #1;
        resetN = 1'b1;
        nv = 0;
        for (int k = 0; k < 16; k++) begin
            tick(k < 10, 100, 100, 1'b0);
            if (bus.out_valid) begin
                total++;
                if (bus.primed !== (nv >= 7)) begin
                    bad++;
                    $display("FAIL rmid_reprime idx=%0d got=%b required=%b", nv, bus.primed, nv >= 7);
                end
                nv++;
            end
        end
        total++;
        if (nv != 10) begin bad++; $display("FAIL rmid_count got=%0d required=10", nv); end
    endtask

    task automatic test_max(input logic [15:0] thr);
        logic [15:0] peak;
        logic        pflag;
        peak  = '0;
        pflag = 1'b0;
        threshold = thr;
        tick(1'b0, 0, 0, 1'b1);
        for (int k = 0; k < 26; k++) begin
            tick(k < 18, (k >= 10 && k < 18) ? 255 : 0, 0, 1'b0);
            if (bus.out_valid && bus.dist_sq[15:0] > peak) begin
                peak  = bus.dist_sq[15:0];
                pflag = bus.edge_flags[0];
            end
        end
        total++;
        if (peak !== 16'd65025) begin bad++; $display("FAIL max_peak thr=%0d got=%0d required=65025", thr, peak); end
        total++;
        if (pflag !== (thr < 16'd65025)) begin
            bad++;
            $display("FAIL max_flag thr=%0d got=%b required=%b", thr, pflag, thr < 16'd65025);
        end
    endtask

    task automatic test_random();
        int p0, p1;
        for (int k = 0; k < 400; k++) begin
            if (k % 50 == 0) begin
                case ($urandom_range(0, 3))
                    0:       threshold = 16'hFFFF;
                    1:       threshold = 16'd0;
                    default: threshold = 16'($urandom_range(0, 20000));
                endcase
            end
            if ($urandom_range(0, 1) == 1) begin
                p0 = $urandom_range(0, 255);
                p1 = $urandom_range(0, 255);
            end else begin
                p0 = $urandom_range(90, 110);
                p1 = $urandom_range(0, 12);
            end
            tick($urandom_range(0, 3) != 0, p0, p1, $urandom_range(0, 59) == 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_pixels = '0;
        test_reset();
        test_constant();
        test_latency();
        test_step(1'b0);
        test_step(1'b1);
        test_flush();
        test_reset_mid();
        test_max(16'd65025);
        test_max(16'd65024);
        test_random();
        for (int k = 0; k < 8; k++) tick(1'b0, 0, 0, 1'b0);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain_pending got=%0d required=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
